// File: rtl/dm_wait_responder_pkg.sv
// dm_wait_responder_pkg: shared FSM encoding and addressing constants
package dm_wait_responder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;
  // Byte-address bits below the word index
  localparam int WORD_OFS = 2;
endpackage

// File: rtl/dm_sram_array.sv
// dm_sram_array: word array with synchronous write and registered read
// Ports: i_clk clock; i_we/i_re write/read enables; i_addr word index;
//        i_wdata write word; o_rdata read word (valid the cycle after i_re).
module dm_sram_array #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);
  logic [31:0] mem_q [2**ADDR_W];
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_addr] <= i_wdata;
    if (i_re) o_rdata <= mem_q[i_addr];
  end
endmodule

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: req/ack data-memory target with fixed wait-state latency
// Ports: i_clk clock; i_rst_n async active-low reset; i_req/i_we/i_addr/i_wdata
//        request from the initiator; o_ack one-cycle completion pulse;
//        o_rdata load data and o_err misalignment flag (valid with o_ack);
//        o_busy high while a transaction is in flight.
module dm_wait_responder
  import dm_wait_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, mis_q, ack_q, err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q, sram_rdata;
  logic              accept, access;
  logic              unused_addr;
  // Upper address bits wrap the access modulo the array depth
  assign unused_addr = ^i_addr[31:ADDR_W+WORD_OFS];
  assign accept = (state_q == IDLE) && i_req;
  // The access fires on the edge after the counter has reached zero, so
  // WAIT_CYCLES = 0 still gives one cycle between acceptance and ack
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? WAIT : access ? ACK : (state_q == ACK) ? IDLE : state_q;
  end
  always_comb begin
    o_busy  = state_q != IDLE;
    o_ack   = ack_q;
    o_err   = err_q;
    o_rdata = (ack_q && !we_q && !err_q) ? sram_rdata : 32'd0;
  end
  assign cnt_d = accept ? WC : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ack_q <= access;
      err_q <= access && mis_q;
      if (accept) begin
        we_q    <= i_we;
        mis_q   <= |i_addr[WORD_OFS-1:0];
        idx_q   <= i_addr[ADDR_W+WORD_OFS-1:WORD_OFS];
        wdata_q <= i_wdata;
      end
    end
  end
  dm_sram_array #(.ADDR_W(ADDR_W)) u_sram (
    .i_clk  (i_clk),
    .i_we   (access && we_q && !mis_q),
    .i_re   (access && !we_q && !mis_q),
    .i_addr (idx_q),
    .i_wdata(wdata_q),
    .o_rdata(sram_rdata)
  );
endmodule

// File: tb/tb_dm_wait_responder.sv
// tb_dm_wait_responder: directed checks of latency, data, misalignment, wrap and reset abort
module tb_dm_wait_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        a_rst_n, a_req, a_we, a_ack, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rst_n, b_req, b_we, b_ack, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  int checks = 0;
  int failures = 0;
  dm_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_req(a_req), .i_we(a_we), .i_addr(a_addr),
    .i_wdata(a_wdata), .o_ack(a_ack), .o_rdata(a_rdata), .o_err(a_err), .o_busy(a_busy)
  );
  dm_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
    .i_wdata(b_wdata), .o_ack(b_ack), .o_rdata(b_rdata), .o_err(b_err), .o_busy(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  // Full WAIT_CYCLES=2 transaction: accept at edge 1, ack from edge 4 to edge 5
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    step();
    chk({tag, "_busy_e1"}, 32'(a_busy), 32'd1);
    chk({tag, "_ack_e1"}, 32'(a_ack), 32'd0);
    step();
    chk({tag, "_ack_e2"}, 32'(a_ack), 32'd0);
    step();
    chk({tag, "_ack_e3"}, 32'(a_ack), 32'd0);
    chk({tag, "_rdata_e3"}, a_rdata, 32'd0);
    step();
    chk({tag, "_ack_e4"}, 32'(a_ack), 32'd1);
    chk({tag, "_rdata_e4"}, a_rdata, exp_rd);
    chk({tag, "_err_e4"}, 32'(a_err), 32'(exp_err));
    a_req = 1'b0;
    step();
    chk({tag, "_ack_e5"}, 32'(a_ack), 32'd0);
    chk({tag, "_rdata_e5"}, a_rdata, 32'd0);
    chk({tag, "_err_e5"}, 32'(a_err), 32'd0);
    chk({tag, "_busy_e5"}, 32'(a_busy), 32'd0);
  endtask
  initial begin
    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    step();
    step();
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    a_txn(1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "st10");
    a_txn(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "ld10");
    a_txn(1'b1, 32'h13, 32'h12345678, 32'd0, 1'b1, "st13_mis");
    a_txn(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "ld10_after_mis");
    a_txn(1'b0, 32'h12, 32'd0, 32'd0, 1'b1, "ld12_mis");
    a_txn(1'b1, 32'h400, 32'hA5A5A5A5, 32'd0, 1'b0, "st400");
    a_txn(1'b0, 32'h000, 32'd0, 32'hA5A5A5A5, 1'b0, "ld000_wrap");
    a_txn(1'b1, 32'h20, 32'h22222222, 32'd0, 1'b0, "st20_prior");
    a_txn(1'b0, 32'h20, 32'd0, 32'h22222222, 1'b0, "ld20_prior");
    // Abort a store one cycle after acceptance
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h11111111;
    step();
    chk("abort_busy_e1", 32'(a_busy), 32'd1);
    step();
    a_req = 1'b0;
    a_rst_n = 1'b0;
    #1;
    chk("abort_busy_async", 32'(a_busy), 32'd0);
    chk("abort_ack_async", 32'(a_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_ack_hold", 32'(a_ack), 32'd0);
      chk("abort_rdata_hold", a_rdata, 32'd0);
    end
    a_rst_n = 1'b1;
    a_txn(1'b0, 32'h20, 32'd0, 32'h22222222, 1'b0, "ld20_after_abort");
    // Zero wait states with i_req held high continuously
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h8; b_wdata = 32'h00000055;
    step();
    chk("z_busy_e1", 32'(b_busy), 32'd1);
    chk("z_ack_e1", 32'(b_ack), 32'd0);
    step();
    chk("z_ack_e2", 32'(b_ack), 32'd1);
    chk("z_err_e2", 32'(b_err), 32'd0);
    step();
    chk("z_ack_e3", 32'(b_ack), 32'd0);
    chk("z_busy_e3", 32'(b_busy), 32'd0);
    step();
    chk("z_ack_e4", 32'(b_ack), 32'd0);
    chk("z_busy_e4", 32'(b_busy), 32'd1);
    step();
    chk("z_ack_e5", 32'(b_ack), 32'd1);
    b_req = 1'b0;
    step();
    chk("z_ack_e6", 32'(b_ack), 32'd0);
    b_req = 1'b1; b_we = 1'b0;
    step();
    chk("z_ld_ack_e1", 32'(b_ack), 32'd0);
    chk("z_ld_rdata_e1", b_rdata, 32'd0);
    step();
    chk("z_ld_ack_e2", 32'(b_ack), 32'd1);
    chk("z_ld_rdata_e2", b_rdata, 32'h00000055);
    b_req = 1'b0;
    step();
    chk("z_ld_rdata_e3", b_rdata, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
